cpu_axi_bridge: RTL and testbench
=================================

# cpu_axi_bridge

Converts the CPU core's two single-cycle SRAM-style ports (instruction and data) into one AXI3 master, so the core can run in the AXI SoC. Sits directly downstream of the core's inst/data SRAM ports and returns read data plus a pipeline stall. One transaction is outstanding at a time. When both ports request in the same cycle, data is served first.

## Interface
- Parameters: none. All constants live in the shared package.
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- inst_en  in  1  instruction fetch request (read only)
- inst_addr  in  32  fetch virtual address, word aligned
- inst_rdata  out  32  fetched word, registered
- data_en  in  1  data access request
- data_wen  in  4  byte strobes; 0 = read
- data_addr  in  32  data virtual address
- data_wdata  in  32  store data, byte lanes already aligned
- data_rdata  out  32  load word, registered
- stall  out  1  freeze the whole core pipeline
- arid/araddr/arsize/arvalid/arready  AXI read address (4/32/3/1 out, 1 in)
- rid/rdata/rresp/rlast/rvalid/rready  AXI read data (4/32/2/1/1 in, 1 out)
- awid/awaddr/awsize/awvalid/awready  AXI write address (4/32/3/1 out, 1 in)
- wid/wdata/wstrb/wlast/wvalid/wready  AXI write data (4/32/4/1/1 out, 1 in)
- bid/bresp/bvalid/bready  AXI write response (4/2/1 in, 1 out)
- Tied outputs: arlen/awlen = 0, arburst/awburst = INCR, lock/cache/prot = 0, wlast = 1.

## Operation
- FSM states: IDLE, D_RD_A, D_RD_D, D_WR, D_B, I_RD_A, I_RD_D, DONE.
- IDLE:
  - data_en → D_WR if data_wen≠0, else D_RD_A.
  - Otherwise inst_en → I_RD_A.
  - Otherwise stay in IDLE.
- D_RD_A / I_RD_A:
  - arvalid=1; arid=1 for data, 0 for inst; arsize=2.
  - Leave on arvalid&&arready.
- D_RD_D / I_RD_D:
  - rready=1.
  - On rvalid, capture rdata into data_rdata or inst_rdata.
- D_WR:
  - awvalid and wvalid both start asserted.
  - Each drops independently after its own handshake (aw_done, w_done flags).
  - Go to D_B when both handshakes are complete.
- D_B: bready=1; leave on bvalid.
- After a data access completes: go to I_RD_A if inst_en, else DONE. After an inst access completes: go to DONE.
- DONE: unconditionally → IDLE.
- stall = (inst_en||data_en) && state≠DONE.
  - Stall is combinational, so it rises in the same cycle a request is first seen.
  - Stall is low for exactly one cycle (DONE); the core advances in that cycle.
- Address map (applied to both ports):
  - 0x8000_0000–0xBFFF_FFFF → {3'b000, va[28:0]}.
  - All other addresses pass through unchanged.
- awsize from data_wen: 4'b1111→2; 0011/1100→1; one-hot→0. awaddr keeps the byte offset from data_addr. wstrb=data_wen.
- AXI rules:
  - A valid, once raised, holds until its handshake.
  - Address and data are registered at state entry and stay stable while valid is high.
- rresp/bresp errors are ignored and treated as completion. rid/bid are not checked, since only one transaction is ever outstanding.
- Reset (async, any state):
  - State → IDLE; all valid/ready outputs → 0; aw_done/w_done → 0.
  - inst_rdata/data_rdata → 0.
  - An in-flight transaction is abandoned.

## Timing
- Zero-wait slave (ready always 1, rvalid one cycle after AR) doing an inst-only read:
  - stall high in cycles 0–2, low in cycle 3.
  - inst_rdata valid in cycle 3.
- Data read followed by inst read: 5 stall cycles, then DONE.
- Data write with aw/w ready and bvalid on the next cycle: D_WR → D_B → DONE.
- Back-pressure extends any state without limit. No timeout.
- inst_rdata/data_rdata hold their values until the next capture.

## Structure
- Shared package cpu_axi_pkg holds:
  - state encoding localparams;
  - AXI fixed constants (BURST_INCR, SIZE_WORD, ID_INST=0, ID_DATA=1).
- Sub-module addr_map: combinational va→pa, instantiated once per port.
- Remaining FSM and registers are in cpu_axi_bridge, about 250 lines of RTL.

## Test plan
- Inst-only fetch, inst_addr=0xBFC0_0000, slave returns 0x2408_0001 → araddr=0x1FC0_0000, arid=0, stall high 3 cycles, inst_rdata=0x2408_0001 in DONE.
- Simultaneous load at 0x8000_0010 and fetch at 0xBFC0_0004 → data AR issued first (arid=1, araddr=0x0000_0010), then inst AR; one DONE cycle; both rdata registers correct.
- Byte store, data_wen=4'b0100, data_addr=0x8000_0022, awready delayed 3 cycles, wready immediate → awsize=0, awaddr=0x0000_0022, wstrb=0100, wvalid drops after its own handshake, D_B reached only after AW completes.
- arready held low 10 cycles → arvalid and araddr stable throughout; stall stays high.
- resetn pulsed low during D_RD_D → all valids/readies 0 immediately, state IDLE; the next request restarts cleanly.
- bresp=SLVERR on a word store → treated as complete; stall drops normally.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// Shared constants for the CPU-to-AXI3 bridge: FSM encoding, fixed AXI fields
// and the strobe-to-size helper.
package cpu_axi_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_D_RD_A = 3'd1;
  localparam state_t S_D_RD_D = 3'd2;
  localparam state_t S_D_WR   = 3'd3;
  localparam state_t S_D_B    = 3'd4;
  localparam state_t S_I_RD_A = 3'd5;
  localparam state_t S_I_RD_D = 3'd6;
  localparam state_t S_DONE   = 3'd7;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [3:0] ID_INST    = 4'd0;
  localparam logic [3:0] ID_DATA    = 4'd1;

  // kseg0/kseg1 window: va[31:30] == 2'b10
  localparam logic [1:0] KSEG01_HI = 2'b10;

  function automatic logic [2:0] size_from_strb(input logic [3:0] strb);
    case (strb)
      4'b1111:         return 3'd2;
      4'b0011, 4'b1100: return 3'd1;
      default:         return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/addr_map.sv
// Fixed virtual-to-physical translation: kseg0/kseg1 fold onto the low 512 MB,
// everything else passes through.
module addr_map
  import cpu_axi_pkg::*;
(
  input  logic [31:0] va,
  output logic [31:0] pa
);

  assign pa = (va[31:30] == KSEG01_HI) ? {3'b000, va[28:0]} : va;

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's inst/data SRAM ports onto one AXI3 master, one
// transaction outstanding, data port served before instruction port.
//
// state    | meaning
// IDLE     | waiting for a request
// D_RD_A   | data read address phase
// D_RD_D   | data read data phase
// D_WR     | data write address + data phases, each retiring on its own
// D_B      | waiting for the write response
// I_RD_A   | instruction read address phase
// I_RD_D   | instruction read data phase
// DONE     | one-cycle stall release so the core can advance
module cpu_axi_bridge
  import cpu_axi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  input  logic        data_en,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        stall,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state, state_nxt;
  logic        aw_done, w_done;
  logic [31:0] inst_pa, data_pa;

  // Single outstanding transaction, so IDs and responses carry no information.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

  addr_map u_map_inst (.va(inst_addr), .pa(inst_pa));
  addr_map u_map_data (.va(data_addr), .pa(data_pa));

  assign arlen   = 4'd0;
  assign arsize  = SIZE_WORD;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = ID_DATA;
  assign awlen   = 4'd0;
  assign awburst = BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = ID_DATA;
  assign wlast   = 1'b1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (data_en)      state_nxt = (data_wen != 4'd0) ? S_D_WR : S_D_RD_A;
        else if (inst_en) state_nxt = S_I_RD_A;
      end
      S_D_RD_A: if (arready) state_nxt = S_D_RD_D;
      S_D_RD_D: if (rvalid)  state_nxt = inst_en ? S_I_RD_A : S_DONE;
      S_D_WR:   if ((aw_done || awready) && (w_done || wready)) state_nxt = S_D_B;
      S_D_B:    if (bvalid)  state_nxt = inst_en ? S_I_RD_A : S_DONE;
      S_I_RD_A: if (arready) state_nxt = S_I_RD_D;
      S_I_RD_D: if (rvalid)  state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    arvalid = (state == S_D_RD_A) || (state == S_I_RD_A);
    rready  = (state == S_D_RD_D) || (state == S_I_RD_D);
    awvalid = (state == S_D_WR) && !aw_done;
    wvalid  = (state == S_D_WR) && !w_done;
    bready  = (state == S_D_B);
    stall   = (inst_en || data_en) && (state != S_DONE);
  end

  // Channel payloads are latched on state entry so they stay stable under valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      arid       <= ID_INST;
      araddr     <= 32'd0;
      awaddr     <= 32'd0;
      awsize     <= 3'd0;
      wdata      <= 32'd0;
      wstrb      <= 4'd0;
      inst_rdata <= 32'd0;
      data_rdata <= 32'd0;
    end else begin
      aw_done <= (state == S_D_WR) && (state_nxt == S_D_WR) && (aw_done || awready);
      w_done  <= (state == S_D_WR) && (state_nxt == S_D_WR) && (w_done || wready);
      if (state_nxt == S_D_RD_A && state != S_D_RD_A) begin
        arid   <= ID_DATA;
        araddr <= data_pa;
      end
      if (state_nxt == S_I_RD_A && state != S_I_RD_A) begin
        arid   <= ID_INST;
        araddr <= inst_pa;
      end
      if (state_nxt == S_D_WR && state != S_D_WR) begin
        awaddr <= data_pa;
        awsize <= size_from_strb(data_wen);
        wdata  <= data_wdata;
        wstrb  <= data_wen;
      end
      if (state == S_D_RD_D && rvalid) data_rdata <= rdata;
      if (state == S_I_RD_D && rvalid) inst_rdata <= rdata;
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge with a delay-configurable AXI slave model.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_en, data_en;
  logic [31:0] inst_addr, data_addr, data_wdata;
  logic [3:0]  data_wen;
  logic [31:0] inst_rdata, data_rdata;
  logic        stall;
  logic [3:0]  arid, awid, wid, arlen, awlen, arcache, awcache;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock;
  logic        arvalid, arready, rready, awvalid, awready, wvalid, wready, wlast, bready;
  logic [3:0]  rid, bid, wstrb;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic        rlast, rvalid, bvalid;

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .stall(stall),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  // slave configuration and observation log
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] iword = 32'd0, dword = 32'd0;
  logic [3:0]  r_id = 4'd0;
  int          ar_cyc, r_cyc, aw_cyc, w_cyc, b_cyc;
  int          arvalid_cycles, awvalid_cycles, wvalid_cycles, ar_unstable;
  int          aw_hs_cyc, w_hs_cyc, b_first;
  logic [31:0] ar_first, aw_addr_seen, w_data_seen;
  logic [2:0]  aw_size_seen;
  logic [3:0]  w_strb_seen;
  logic [31:0] ar_addr_log[$];
  logic [3:0]  ar_id_log[$];

  task automatic clear_log();
    ar_addr_log.delete();
    ar_id_log.delete();
    arvalid_cycles = 0; awvalid_cycles = 0; wvalid_cycles = 0; ar_unstable = 0;
    aw_hs_cyc = -1; w_hs_cyc = -1; b_first = -1;
    aw_addr_seen = '1; aw_size_seen = '1; w_strb_seen = '1; w_data_seen = '1;
  endtask

  function automatic logic [31:0] log_addr(input int i);
    return (i < ar_addr_log.size()) ? ar_addr_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] log_id(input int i);
    return (i < ar_id_log.size()) ? 32'(ar_id_log[i]) : 32'hFFFF_FFFF;
  endfunction

  initial begin
    arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 1; bid = 0; bresp = 0;
    ar_cyc = 0; r_cyc = 0; aw_cyc = 0; w_cyc = 0; b_cyc = 0;
    clear_log();
    forever begin
      @(negedge clk);
      if (arvalid) begin
        if (ar_cyc == 0) ar_first = araddr;
        else if (araddr != ar_first) ar_unstable++;
        arready = (ar_cyc >= ar_delay);
        ar_cyc++; arvalid_cycles++;
        if (arready) begin
          ar_addr_log.push_back(araddr);
          ar_id_log.push_back(arid);
          r_id = arid;
        end
      end else begin
        arready = 0; ar_cyc = 0;
      end
      if (rready) begin
        rvalid = (r_cyc >= r_delay); r_cyc++;
        rdata  = (r_id == 4'd1) ? dword : iword;
      end else begin
        rvalid = 0; r_cyc = 0;
      end
      if (awvalid) begin
        awready = (aw_cyc >= aw_delay); aw_cyc++; awvalid_cycles++;
        if (awready) begin aw_addr_seen = awaddr; aw_size_seen = awsize; aw_hs_cyc = cyc; end
      end else begin
        awready = 0; aw_cyc = 0;
      end
      if (wvalid) begin
        wready = (w_cyc >= w_delay); w_cyc++; wvalid_cycles++;
        if (wready) begin w_strb_seen = wstrb; w_data_seen = wdata; w_hs_cyc = cyc; end
      end else begin
        wready = 0; w_cyc = 0;
      end
      if (bready) begin
        if (b_first < 0) b_first = cyc;
        bvalid = (b_cyc >= b_delay); b_cyc++; bresp = bresp_cfg;
      end else begin
        bvalid = 0; b_cyc = 0;
      end
    end
  end

  // Counts stalled cycles from now until the DONE cycle (stall low).
  task automatic wait_done(output int n);
    n = 0;
    while (stall && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic finish_txn(input string tag);
    inst_en = 0; data_en = 0; data_wen = 0;
    @(posedge clk); #1;
    chk(tag, 32'(stall), 32'd0);
  endtask

  int n;

  initial begin
    resetn = 0; inst_en = 0; data_en = 0; data_wen = 0;
    inst_addr = 0; data_addr = 0; data_wdata = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    chk("tied_len_burst", 32'({arlen, awlen, arburst, awburst}), 32'h0005);
    chk("tied_wlast", 32'(wlast), 32'd1);
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;

    // inst-only fetch from kseg1
    clear_log();
    iword = 32'h2408_0001;
    inst_en = 1; inst_addr = 32'hBFC0_0000; #1;
    wait_done(n);
    chk("t1_stall_cycles", 32'(n), 32'd3);
    chk("t1_inst_rdata", inst_rdata, 32'h2408_0001);
    chk("t1_araddr", log_addr(0), 32'h1FC0_0000);
    chk("t1_arid", log_id(0), 32'd0);
    finish_txn("t1_idle_stall");

    // simultaneous load and fetch: data first
    clear_log();
    dword = 32'h1122_3344; iword = 32'h5566_7788;
    data_en = 1; data_wen = 0; data_addr = 32'h8000_0010;
    inst_en = 1; inst_addr = 32'hBFC0_0004; #1;
    wait_done(n);
    chk("t2_stall_cycles", 32'(n), 32'd5);
    chk("t2_ar_count", 32'(ar_addr_log.size()), 32'd2);
    chk("t2_ar0_id", log_id(0), 32'd1);
    chk("t2_ar0_addr", log_addr(0), 32'h0000_0010);
    chk("t2_ar1_id", log_id(1), 32'd0);
    chk("t2_ar1_addr", log_addr(1), 32'h1FC0_0004);
    chk("t2_data_rdata", data_rdata, 32'h1122_3344);
    chk("t2_inst_rdata", inst_rdata, 32'h5566_7788);
    finish_txn("t2_idle_stall");

    // byte store, awready late, wready immediate
    clear_log();
    aw_delay = 3;
    data_en = 1; data_wen = 4'b0100; data_addr = 32'h8000_0022; data_wdata = 32'hAABB_CCDD; #1;
    wait_done(n);
    chk("t3_stall_cycles", 32'(n), 32'd6);
    chk("t3_awsize", 32'(aw_size_seen), 32'd0);
    chk("t3_awaddr", aw_addr_seen, 32'h0000_0022);
    chk("t3_wstrb", 32'(w_strb_seen), 32'h4);
    chk("t3_wdata", w_data_seen, 32'hAABB_CCDD);
    chk("t3_wvalid_cycles", 32'(wvalid_cycles), 32'd1);
    chk("t3_awvalid_cycles", 32'(awvalid_cycles), 32'd4);
    chk("t3_w_before_aw", 32'(aw_hs_cyc - w_hs_cyc), 32'd3);
    chk("t3_db_after_aw", 32'(b_first - aw_hs_cyc), 32'd1);
    aw_delay = 0;
    finish_txn("t3_idle_stall");

    // arready held off 10 cycles, pass-through address
    clear_log();
    ar_delay = 10; dword = 32'hCAFE_F00D;
    data_en = 1; data_wen = 0; data_addr = 32'h0000_1000; #1;
    wait_done(n);
    chk("t4_stall_cycles", 32'(n), 32'd13);
    chk("t4_arvalid_cycles", 32'(arvalid_cycles), 32'd11);
    chk("t4_ar_unstable", 32'(ar_unstable), 32'd0);
    chk("t4_araddr", log_addr(0), 32'h0000_1000);
    chk("t4_data_rdata", data_rdata, 32'hCAFE_F00D);
    ar_delay = 0;
    finish_txn("t4_idle_stall");

    // reset in the middle of a read data phase
    clear_log();
    r_delay = 5; iword = 32'h0BAD_F00D;
    inst_en = 1; inst_addr = 32'h8000_0100; #1;
    for (int k = 0; k < 20 && !rready; k++) begin
      @(posedge clk); #1;
    end
    chk("t5_in_rd_d", 32'(rready), 32'd1);
    @(posedge clk); #1;
    resetn = 0; #1;
    chk("t5_rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
    chk("t5_rst_inst_rdata", inst_rdata, 32'd0);
    chk("t5_rst_data_rdata", data_rdata, 32'd0);
    inst_en = 0;
    @(negedge clk); resetn = 1; r_delay = 0;
    @(posedge clk); #1;
    chk("t5_idle_stall", 32'(stall), 32'd0);
    clear_log();
    inst_en = 1; #1;
    wait_done(n);
    chk("t5_restart_cycles", 32'(n), 32'd3);
    chk("t5_restart_araddr", log_addr(0), 32'h0000_0100);
    chk("t5_restart_rdata", inst_rdata, 32'h0BAD_F00D);
    finish_txn("t5_done_idle");

    // word store with SLVERR, bvalid late
    clear_log();
    bresp_cfg = 2'b10; b_delay = 2;
    data_en = 1; data_wen = 4'b1111; data_addr = 32'h0000_2000; data_wdata = 32'h1234_5678; #1;
    wait_done(n);
    chk("t6_stall_cycles", 32'(n), 32'd5);
    chk("t6_awsize", 32'(aw_size_seen), 32'd2);
    chk("t6_awaddr", aw_addr_seen, 32'h0000_2000);
    chk("t6_wstrb", 32'(w_strb_seen), 32'hF);
    bresp_cfg = 2'b00; b_delay = 0;
    finish_txn("t6_idle_stall");

    // halfword store followed by a fetch
    clear_log();
    iword = 32'h3C1D_BFC0;
    data_en = 1; data_wen = 4'b0011; data_addr = 32'h8000_0002; data_wdata = 32'h0000_BEEF;
    inst_en = 1; inst_addr = 32'hBFC0_0008; #1;
    wait_done(n);
    chk("t7_stall_cycles", 32'(n), 32'd5);
    chk("t7_awsize", 32'(aw_size_seen), 32'd1);
    chk("t7_awaddr", aw_addr_seen, 32'h0000_0002);
    chk("t7_wstrb", 32'(w_strb_seen), 32'h3);
    chk("t7_ar_count", 32'(ar_addr_log.size()), 32'd1);
    chk("t7_araddr", log_addr(0), 32'h1FC0_0008);
    chk("t7_inst_rdata", inst_rdata, 32'h3C1D_BFC0);
    finish_txn("t7_idle_stall");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
